// File: rtl/dot_product_pkg.sv
// Shared types and width helpers for the dot-product MAC.
//   state_t : accumulator FSM states (ACCUM, DRAIN, HOLD)
//   prod_w  : width of one signed lane product
//   sum_w   : width of the exact sum of all lane products
package dot_product_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int unsigned prod_w(input int unsigned data_w);
    return 2 * data_w;
  endfunction

  function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned lanes);
    return 2 * data_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/dot_product_lane_sum.sv
// Combinational lane arithmetic for the dot-product MAC.
//   a, b    : packed signed elements, lane i at [DATA_W*i +: DATA_W]
//   prod    : packed signed products of a and b (feeds the S1 register)
//   prod_q  : registered products from S1
//   sum     : exact signed sum of the prod_q lanes (feeds the S2 adder)
module dot_product_lane_sum
  import dot_product_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned PROD_W = prod_w(DATA_W),
  localparam int unsigned SUM_W  = sum_w(DATA_W, LANES)
) (
  input  logic [DATA_W*LANES-1:0]  a,
  input  logic [DATA_W*LANES-1:0]  b,
  output logic [PROD_W*LANES-1:0]  prod,
  input  logic [PROD_W*LANES-1:0]  prod_q,
  output logic signed [SUM_W-1:0]  sum
);

  // Full-precision signed product per lane.
  always_comb begin : mul_lanes
    logic signed [DATA_W-1:0] ai;
    logic signed [DATA_W-1:0] bi;
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      ai = a[DATA_W*i +: DATA_W];
      bi = b[DATA_W*i +: DATA_W];
      prod[PROD_W*i +: PROD_W] = PROD_W'(ai) * PROD_W'(bi);
    end
  end

  // Lane sum is sized so it can never overflow, whatever ACC_W is.
  always_comb begin : add_lanes
    logic signed [PROD_W-1:0] pi;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      pi  = prod_q[PROD_W*i +: PROD_W];
      sum = sum + SUM_W'(pi);
    end
  end

endmodule

// File: rtl/dot_product_mac.sv
// Streaming signed dot-product accumulator.
// Beats of LANES element pairs are multiplied (S1), lane-summed and added
// into the accumulator (S2); the vector's result is presented on a
// valid/ready output once the pipeline has drained after the in_last beat.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input beat handshake
//   in_a, in_b, in_last   : packed operands and end-of-vector marker
//   out_valid/out_ready   : result handshake
//   out_result            : signed dot product
//   out_beats             : accepted beats (saturating)
//   out_ovf               : accumulator clamped during this vector
// Build option: DOT_PRODUCT_MAC_SAT_EN selects saturating accumulation with
// a sticky overflow flag; otherwise the accumulator wraps and out_ovf is 0.
module dot_product_mac
  import dot_product_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 2 * DATA_W + 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W*LANES-1:0]    in_a,
  input  logic [DATA_W*LANES-1:0]    in_b,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    out_result,
  output logic [CNT_W-1:0]           out_beats,
  output logic                       out_ovf
);

  localparam int unsigned PROD_W = prod_w(DATA_W);
  localparam int unsigned SUM_W  = sum_w(DATA_W, LANES);

  state_t state, state_next;
  logic   drain_q, drain_next;
  logic   accept_c, take_c;

  logic [PROD_W*LANES-1:0] prod_c;
  logic [PROD_W*LANES-1:0] s1_prod;
  logic                    s1_valid;
  logic signed [SUM_W-1:0] lane_sum_c;

  logic signed [ACC_W-1:0] acc, acc_next_c;
  logic                    ovf, ovf_next_c;
  logic [CNT_W-1:0]        beats;

  assign accept_c = in_valid && in_ready;
  assign take_c   = out_valid && out_ready;

  dot_product_lane_sum #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_lane_sum (
    .a      (in_a),
    .b      (in_b),
    .prod   (prod_c),
    .prod_q (s1_prod),
    .sum    (lane_sum_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ACCUM;
      drain_q <= 1'b0;
    end else begin
      state   <= state_next;
      drain_q <= drain_next;
    end
  end

  // Next state: DRAIN covers the two cycles the last beat needs to clear S1/S2.
  always_comb begin
    state_next = state;
    drain_next = 1'b0;
    case (state)
      ACCUM: if (accept_c && in_last) state_next = DRAIN;
      DRAIN: begin
        drain_next = 1'b1;
        if (drain_q) state_next = HOLD;
      end
      HOLD:  if (take_c) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

`ifdef DOT_PRODUCT_MAC_SAT_EN
  localparam int unsigned EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [EXT_W-1:0] sum_ext_c;

  // Exact add in a widened domain, then clamp into the accumulator range.
  always_comb begin
    sum_ext_c  = EXT_W'(acc) + EXT_W'(lane_sum_c);
    acc_next_c = ACC_W'(sum_ext_c);
    ovf_next_c = ovf;
    if (sum_ext_c > EXT_W'(ACC_MAX)) begin
      acc_next_c = ACC_MAX;
      ovf_next_c = 1'b1;
    end else if (sum_ext_c < EXT_W'(ACC_MIN)) begin
      acc_next_c = ACC_MIN;
      ovf_next_c = 1'b1;
    end
  end
`else
  // Modulo-2^ACC_W accumulation; overflow is never reported.
  always_comb begin
    acc_next_c = acc + ACC_W'(lane_sum_c);
    ovf_next_c = 1'b0;
  end
`endif

  // Pipeline, accumulator, beat counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready   <= 1'b1;
      s1_valid   <= 1'b0;
      s1_prod    <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      beats      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_beats  <= '0;
      out_ovf    <= 1'b0;
    end else begin
      in_ready <= (state_next == ACCUM);
      s1_valid <= accept_c;
      if (accept_c) s1_prod <= prod_c;

      if (take_c) begin
        acc   <= '0;
        ovf   <= 1'b0;
        beats <= '0;
      end else begin
        if (s1_valid) begin
          acc <= acc_next_c;
          ovf <= ovf_next_c;
        end
        if (accept_c && (beats != '1)) beats <= beats + CNT_W'(1);
      end

      // Capture one cycle into HOLD, once the final S2 add has landed.
      if (take_c) begin
        out_valid <= 1'b0;
      end else if ((state == HOLD) && !out_valid) begin
        out_valid  <= 1'b1;
        out_result <= acc;
        out_beats  <= beats;
        out_ovf    <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// Bench for dot_product_mac: directed scenarios with literal expectations
// plus randomized vectors checked every cycle against a behavioural model.
module tb_dot_product_mac;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned W      = DATA_W * LANES;
  localparam longint ACC_MAXV = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MINV = -(64'sd1 <<< (ACC_W - 1));
  localparam int     CNT_MAXV = (1 << CNT_W) - 1;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [W-1:0]            in_a;
  logic [W-1:0]            in_b;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_result;
  logic [CNT_W-1:0]        out_beats;
  logic                    out_ovf;

  dot_product_mac #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_beats  (out_beats),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint res;
    int     beats;
    bit     ovf;
    longint due;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0;
  longint m_acc = 0;
  int     m_beats = 0;
  bit     m_ovf = 1'b0;
  bit     chk_en = 1'b0;

  function automatic bit exp_valid();
    return (q.size() > 0) && (cyc >= q[0].due);
  endfunction

  always @(posedge clk) begin
    longint ls;
    logic signed [DATA_W-1:0] ea, eb;
    if (!rst_n) begin
      q.delete();
      m_acc = 0; m_beats = 0; m_ovf = 1'b0;
    end else if (exp_valid() && out_ready) begin
      void'(q.pop_front());
    end else if ((q.size() == 0) && in_valid) begin
      ls = 0;
      for (int i = 0; i < LANES; i++) begin
        ea = in_a[DATA_W*i +: DATA_W];
        eb = in_b[DATA_W*i +: DATA_W];
        ls += longint'(ea) * longint'(eb);
      end
      m_acc += ls;
`ifdef DOT_PRODUCT_MAC_SAT_EN
      if (m_acc > ACC_MAXV) begin m_acc = ACC_MAXV; m_ovf = 1'b1; end
      if (m_acc < ACC_MINV) begin m_acc = ACC_MINV; m_ovf = 1'b1; end
`else
      m_acc = (m_acc <<< (64 - ACC_W)) >>> (64 - ACC_W);
`endif
      if (m_beats < CNT_MAXV) m_beats++;
      if (in_last) begin
        q.push_back('{res: m_acc, beats: m_beats, ovf: m_ovf, due: cyc + 4});
        m_acc = 0; m_beats = 0; m_ovf = 1'b0;
      end
    end
    cyc++;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", longint'(out_valid), longint'(exp_valid()));
      chk("in_ready", longint'(in_ready), longint'(q.size() == 0));
      if (exp_valid()) begin
        chk("out_result", longint'(out_result), q[0].res);
        chk("out_beats", longint'(out_beats), longint'(q[0].beats));
        chk("out_ovf", longint'(out_ovf), longint'(q[0].ovf));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [W-1:0] pack(input int v0, input int v1, input int v2, input int v3);
    logic [W-1:0] r;
    r = '0;
    r[DATA_W*0 +: DATA_W] = DATA_W'(v0);
    r[DATA_W*1 +: DATA_W] = DATA_W'(v1);
    r[DATA_W*2 +: DATA_W] = DATA_W'(v2);
    r[DATA_W*3 +: DATA_W] = DATA_W'(v3);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_timeout", longint'(n), 0);
    tick();
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) chk("result_timeout", longint'(n), 0);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int len;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    idle(2);
    rst_n = 1'b1;

    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_result", longint'(out_result), 0);
    chk("rst_out_beats", longint'(out_beats), 0);
    chk("rst_out_ovf", longint'(out_ovf), 0);
    chk_en = 1'b1;

    // Single beat {1,2,3,4}.{5,6,7,8} = 70, valid 3 cycles after acceptance.
    send(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1);
    wait_valid(lat);
    chk("s1_latency", longint'(lat), 3);
    chk("s1_result", longint'(out_result), 70);
    chk("s1_beats", longint'(out_beats), 1);
    ack();

    // Three beats of -24 with idle gaps, then a held result.
    for (int k = 0; k < 3; k++) begin
      send(pack(-2, -2, -2, -2), pack(3, 3, 3, 3), k == 2);
      if (k < 2) idle(2);
    end
    wait_valid(lat);
    chk("s2_result", longint'(out_result), -72);
    chk("s2_beats", longint'(out_beats), 3);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_last  = 1'($urandom);
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_in_ready", longint'(in_ready), 0);
      chk("hold_result", longint'(out_result), -72);
      tick();
    end
    in_valid = 1'b0;
    ack();
    chk("release_in_ready", longint'(in_ready), 1);
    chk("release_out_valid", longint'(out_valid), 0);

    // Reset mid-vector discards the partial; only the fresh result appears.
    send(pack(9, 9, 9, 9), pack(9, 9, 9, 9), 1'b0);
    send(pack(5, 5, 5, 5), pack(7, 7, 7, 7), 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b1);
    wait_valid(lat);
    chk("rst_vec_result", longint'(out_result), 4);
    chk("rst_vec_beats", longint'(out_beats), 1);
    ack();

    // Large products: clamp or wrap depending on the build.
    send(pack(127, 127, 127, 127), pack(127, 127, 127, 127), 1'b1);
    wait_valid(lat);
`ifdef DOT_PRODUCT_MAC_SAT_EN
    chk("big_result", longint'(out_result), 32767);
    chk("big_ovf", longint'(out_ovf), 1);
`else
    chk("big_result", longint'(out_result), -1020);
    chk("big_ovf", longint'(out_ovf), 0);
`endif
    ack();

    // Random back-to-back vectors with out_ready tied high.
    out_ready = 1'b1;
    for (int v = 0; v < 15; v++) begin
      len = int'($urandom_range(1, 20));
      for (int k = 0; k < len; k++) begin
        send(W'($urandom), W'($urandom), k == len - 1);
        idle(int'($urandom_range(0, 2)));
      end
    end
    idle(8);
    out_ready = 1'b0;

    // Random vectors with delayed result acceptance.
    for (int v = 0; v < 10; v++) begin
      len = int'($urandom_range(1, 18));
      for (int k = 0; k < len; k++) begin
        send(W'($urandom), W'($urandom), k == len - 1);
        idle(int'($urandom_range(0, 1)));
      end
      wait_valid(lat);
      idle(int'($urandom_range(0, 6)));
      ack();
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_mac.md
DOT_PRODUCT_MAC -- requirements
Module: dot_product_mac

Interface
REQ-001 SHALL have parameter LANES, default 8: vector elements consumed per input beat.
REQ-002 SHALL have parameter DATA_W, default 32: signed element width.
REQ-003 SHALL have parameter ACC_W, default 2*DATA_W+16: signed accumulator/result width, at least 2*DATA_W+clog2(LANES).
REQ-004 SHALL have parameter CNT_W, default 16: beat-counter width.
REQ-005 Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: synchronous, active-low reset.
- in_valid  in  1: beat valid.
- in_ready  out  1: beat accepted when in_valid&&in_ready.
- in_a  in  DATA_W*LANES: packed A elements, lane i at [DATA_W*i +: DATA_W].
- in_b  in  DATA_W*LANES: packed B elements, same packing as in_a.
- in_last  in  1: final beat of the current vector.
- out_valid  out  1: result valid.
- out_ready  in  1: result taken when out_valid&&out_ready.
- out_result  out  ACC_W: signed dot product.
- out_beats  out  CNT_W: beats accumulated into out_result.
- out_ovf  out  1: accumulator overflow flag for this result.

Function
REQ-006 SHALL compute the signed sum over all accepted beats of the sum over lanes of a[i]*b[i]; products SHALL be 2*DATA_W bits, sign-extended to ACC_W before summing.
REQ-007 SHALL pipeline in two register stages: S1 registers the LANES products; S2 registers the lane-sum added to the accumulator.
REQ-008 SHALL implement FSM ACCUM -> DRAIN on an accepted in_last beat, DRAIN -> HOLD after 2 cycles, HOLD -> ACCUM on an out_ready handshake.
REQ-009 in_ready SHALL be 1 only in ACCUM.
REQ-010 out_valid SHALL be 1 only in HOLD; out_result, out_beats and out_ovf SHALL stay stable while out_valid && !out_ready.
REQ-011 Latency SHALL be: out_valid rises exactly 3 cycles after the clock edge accepting the in_last beat.
REQ-012 Cycles with in_valid=0 in ACCUM SHALL not alter the accumulator or the beat count.
REQ-013 The beat counter SHALL saturate at 2^CNT_W-1; accumulation SHALL continue past that point.
REQ-014 On the HOLD->ACCUM handshake, accumulator, counter and overflow flag SHALL clear, so the next vector starts from 0 and can be accepted in the following cycle.
REQ-015 in_last on a vector's first beat SHALL yield a single-beat result with out_beats=1.
REQ-016 in_a, in_b and in_last SHALL be ignored when not accepted.

Reset
REQ-017 With rst_n=0 at a clock edge: state=ACCUM, accumulator=0, counter=0, pipeline valids=0, out_valid=0, out_result=0, out_beats=0, out_ovf=0, in_ready=1 on the following cycle.
REQ-018 Reset mid-vector, or during DRAIN or HOLD, SHALL discard the partial or pending result without emitting it.

Configuration
REQ-019 Macro DOT_PRODUCT_MAC_SAT_EN defined: each S2 addition SHALL clamp to the signed ACC_W range, and out_ovf SHALL be sticky per vector once any clamp occurs.
REQ-020 Macro DOT_PRODUCT_MAC_SAT_EN undefined: the accumulator SHALL wrap modulo 2^ACC_W, and out_ovf SHALL be constant 0.

Structure
REQ-021 Package dot_product_pkg SHALL hold the FSM state typedef (ACCUM, DRAIN, HOLD) and the localparam helpers for product width and lane-sum width.
REQ-022 The lane products and lane sum SHALL be placed in one sub-module, dot_product_lane_sum (combinational, LANES/DATA_W parameters); FSM, pipeline and accumulator SHALL stay in dot_product_mac.

Verification
REQ-023 The bench SHALL cover these scenarios:
- LANES=4: one beat a={1,2,3,4}, b={5,6,7,8}, last -> out_result=70, out_beats=1, out_valid 3 cycles after acceptance.
- LANES=4: 3 beats, each a={-2,-2,-2,-2}, b={3,3,3,3}, with 2 idle cycles between beats -> out_result=-72, out_beats=3.
- After the last beat, hold out_ready=0 for 5 cycles -> out_valid=1, out_result constant, in_ready=0; then out_ready=1 -> next cycle in_ready=1 and the next vector starts from 0.
- Assert rst_n=0 after 2 of 4 beats, then send a fresh 1-beat vector {1,1,1,1}·{1,1,1,1} -> only out_result=4 emitted.
- DATA_W=8, ACC_W=16, LANES=4, a=b={127,127,127,127}, 1 beat -> with DOT_PRODUCT_MAC_SAT_EN: 32767, out_ovf=1; without: -1020, out_ovf=0.
- Back-to-back vectors with out_ready tied 1 -> each result matches the reference model; no beat lost or duplicated.
